// File: rtl/mem_arb.sv
// Two-port memory arbiter/sequencer for the LC2K core.
// Accepts fetch reads and data loads/stores and runs one access at a time through
// IDLE -> ACCESS -> RESP. Each access then returns a one-cycle response pulse.
// Build option: define MEM_ARB_RR_EN for round-robin arbitration between the two ports.
// Without it, the data port always wins contention.
module mem_arb #(
  parameter int unsigned ADDR_LIMIT = 65536,
  parameter int unsigned DATA_W     = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req_valid,
  input  logic [31:0]       if_req_addr,
  output logic              if_req_ready,
  output logic              if_resp_valid,
  output logic [DATA_W-1:0] if_resp_data,
  input  logic              d_req_valid,
  input  logic              d_req_we,
  input  logic [31:0]       d_req_addr,
  input  logic [DATA_W-1:0] d_req_wdata,
  output logic              d_req_ready,
  output logic              d_resp_valid,
  output logic [DATA_W-1:0] d_resp_data,
  output logic [31:0]       mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              addr_err
);

  typedef enum logic [1:0] {StIdle, StAccess, StResp} state_e;

  state_e            state_q;
  logic              grant_data_q;  // 1 = current access belongs to the data port
  logic              we_q;
  logic              in_range_q;
  logic [DATA_W-1:0] resp_data_q;
  logic              if_resp_q;
  logic              d_resp_q;

  logic              d_pri;         // data port wins when both ports are valid
  logic              contention;
  logic              if_hs;
  logic              d_hs;
  logic [31:0]       req_addr;
  logic              req_in_range;

`ifdef MEM_ARB_RR_EN
  logic last_grant_q;  // 1 = data port was granted most recently
  assign d_pri = ~last_grant_q;
`else
  assign d_pri = 1'b1;
`endif

  // Ready/handshake decode: only IDLE accepts, and the loser of contention sees ready low.
  always_comb begin
    contention   = if_req_valid & d_req_valid;
    if_req_ready = 1'b0;
    d_req_ready  = 1'b0;
    if (state_q == StIdle && !rst) begin
      if_req_ready = ~(contention & d_pri);
      d_req_ready  = ~(contention & ~d_pri);
    end
    if_hs        = if_req_valid & if_req_ready;
    d_hs         = d_req_valid & d_req_ready;
    req_addr     = d_hs ? d_req_addr : if_req_addr;
    req_in_range = req_addr < 32'(ADDR_LIMIT);
  end

  // Sequencer: latch a granted request, run the memory cycle, then pulse the response.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      grant_data_q <= 1'b0;
      we_q         <= 1'b0;
      in_range_q   <= 1'b0;
      resp_data_q  <= '0;
      if_resp_q    <= 1'b0;
      d_resp_q     <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      addr_err     <= 1'b0;
`ifdef MEM_ARB_RR_EN
      last_grant_q <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        StIdle: begin
          if (d_hs || if_hs) begin
            grant_data_q <= d_hs;
            we_q         <= d_hs & d_req_we;
            in_range_q   <= req_in_range;
            mem_addr     <= req_addr;
            // Fetches carry no write data, so the last store data is left in place.
            if (d_hs) mem_wdata <= d_req_wdata;
            if (!req_in_range) addr_err <= 1'b1;
`ifdef MEM_ARB_RR_EN
            last_grant_q <= d_hs;
`endif
            state_q <= StAccess;
          end
        end
        StAccess: begin
          resp_data_q <= (we_q || !in_range_q) ? '0 : mem_rdata;
          if_resp_q   <= ~grant_data_q;
          d_resp_q    <= grant_data_q;
          state_q     <= StResp;
        end
        StResp: begin
          if_resp_q <= 1'b0;
          d_resp_q  <= 1'b0;
          state_q   <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Write strobe is combinational so a reset arriving mid-access blocks the write that cycle.
  assign mem_we        = (state_q == StAccess) & we_q & in_range_q & ~rst;
  assign if_resp_valid = if_resp_q;
  assign d_resp_valid  = d_resp_q;
  assign if_resp_data  = resp_data_q;
  assign d_resp_data   = resp_data_q;

endmodule
